// File: rtl/spi_cmd_master_if.sv
// Host-side command and read-response interface of spi_cmd_master.
interface spi_cmd_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;

  // Host: issues commands and consumes read responses.
  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rd_valid, rd_data, busy
  );

  // Command engine: accepts commands and returns read data.
  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/spi_cmd_master.sv
// Serialises host RAM commands into SS_n/MOSI frames for the clk-synchronous
// SPI slave and captures the MISO byte returned by read-data commands.
module spi_cmd_master #(
  parameter int unsigned RD_LAT  = 1,  // cycles from last MOSI bit to first MISO sample (0..7)
  parameter int unsigned GAP_CYC = 1   // minimum SS_n-high cycles between frames (1..15)
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_cmd_master_if.slave host,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SEL, SHIFT, RD_WAIT, RD_SHIFT, GAP
  } state_t;

  localparam logic [3:0] RD_LAT_M1 = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
  localparam logic [3:0] GAP_M1    = 4'(GAP_CYC - 1);
  localparam logic [3:0] W_MSB     = 4'd9;
  localparam logic [3:0] RX_MSB    = 4'd7;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;      // down-counter shared by all timed states
  logic [9:0] w;                  // latched {cmd_type, cmd_data}
  logic [6:0] rx_sr;              // first seven MISO samples, oldest at the top
  logic       accept;
  logic       rd_done;
  logic       frame_next;
  logic       mosi_next;

  logic       cmd_ready_q;
  logic       busy_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  assign host.cmd_ready = cmd_ready_q;
  assign host.busy      = busy_q;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;

  // cmd_ready is only ever high in IDLE, so this is the IDLE-only accept.
  assign accept  = (state == IDLE) && cmd_ready_q && host.cmd_valid;
  assign rd_done = (state == RD_SHIFT) && (cnt == 4'd0);

  // Next-state and frame-position logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          next_cnt   = 4'd0;
        end
      end
      SETUP: next_state = SEL;
      SEL: begin
        next_state = SHIFT;
        next_cnt   = W_MSB;
      end
      SHIFT: begin
        if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
        end else if (w[9:8] == 2'b11) begin
          if (RD_LAT > 0) begin
            next_state = RD_WAIT;
            next_cnt   = RD_LAT_M1;
          end else begin
            next_state = RD_SHIFT;
            next_cnt   = RX_MSB;
          end
        end else begin
          next_state = GAP;
          next_cnt   = GAP_M1;
        end
      end
      RD_WAIT: begin
        if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
        end else begin
          next_state = RD_SHIFT;
          next_cnt   = RX_MSB;
        end
      end
      RD_SHIFT: begin
        if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
        end else begin
          next_state = GAP;
          next_cnt   = GAP_M1;
        end
      end
      GAP: begin
        if (cnt != 4'd0) next_cnt = cnt - 4'd1;
        else             next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Pin values for the coming cycle, so SS_n/MOSI can be registered.
  always_comb begin
    frame_next = next_state inside {SETUP, SEL, SHIFT, RD_WAIT, RD_SHIFT};
    mosi_next  = 1'b0;
    if (next_state == SEL)        mosi_next = w[9];
    else if (next_state == SHIFT) mosi_next = w[next_cnt];
  end

  // State, counter and command word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      w     <= 10'd0;
      rx_sr <= 7'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register updates from the same pre-edge values.
      state <= next_state;
      cnt   <= next_cnt;
      if (accept)             w     <= {host.cmd_type, host.cmd_data};
      if (state == RD_SHIFT)  rx_sr <= {rx_sr[5:0], MISO};
    end
  end

  // Registered outputs; reset aborts any frame and releases SS_n at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      SS_n        <= ~frame_next;
      MOSI        <= mosi_next;
      cmd_ready_q <= (next_state == IDLE);
      busy_q      <= (next_state != IDLE);
      rd_valid_q  <= rd_done;
      if (rd_done) rd_data_q <= {rx_sr, MISO};
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master with a behavioural SPI slave/RAM model.
module tb_spi_cmd_master;
  localparam int RD_LAT       = 1;
  localparam int GAP_CYC      = 2;
  localparam int RD_FRAME_LEN = 12 + RD_LAT + 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n;
  logic MOSI;
  logic MISO  = 1'b1;

  spi_cmd_master_if bus ();

  spi_cmd_master #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (bus.slave),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- slave / RAM model (samples at negedge, mid-cycle) ----
  logic [7:0]  ram [256] = '{8'h03: 8'hFE, default: 8'h00};
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  rd_addr = 8'h00;
  logic [31:0] fbits = 32'd0;
  int          flen = 0;
  logic [31:0] last_bits = 32'd0;
  int          last_len = 0;
  logic [9:0]  w_rx = 10'd0;
  logic [9:0]  last_w = 10'd0;
  logic        rd_frame = 1'b0;
  logic [7:0]  rbyte = 8'h00;
  int          frame_done = 0;
  int          abort_cnt = 0;
  int          hi_cnt = 0;
  int          start_cnt = 0;
  int          gap_log [64];

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (flen == 0) begin
        gap_log[start_cnt % 64] = hi_cnt;
        start_cnt++;
        hi_cnt = 0;
      end
      fbits = {fbits[30:0], MOSI};
      flen++;
      if (flen == 12) begin
        w_rx     = fbits[9:0];
        rd_frame = (fbits[9:8] == 2'b11);
        rbyte    = ram[rd_addr];
      end
      if (rd_frame && flen >= 13 + RD_LAT && flen <= 20 + RD_LAT)
        MISO = rbyte[7 - (flen - 13 - RD_LAT)];
      else
        MISO = 1'b1;
    end else begin
      MISO = 1'b1;
      hi_cnt++;
      if (flen > 0) begin
        last_bits = fbits;
        last_len  = flen;
        if (flen == (rd_frame ? RD_FRAME_LEN : 12)) begin
          frame_done++;
          last_w = w_rx;
          case (w_rx[9:8])
            2'b00:   wr_addr = w_rx[7:0];
            2'b01:   ram[wr_addr] = w_rx[7:0];
            2'b10:   rd_addr = w_rx[7:0];
            default: ;
          endcase
        end else begin
          abort_cnt++;
        end
        flen     = 0;
        fbits    = 32'd0;
        rd_frame = 1'b0;
      end
    end
  end

  // ---------------- rd_valid monitor ------------------------------------
  int         rdv_cnt = 0;
  int         rdv_misplaced = 0;
  logic [7:0] rdv_data = 8'h00;
  logic       prev_ss = 1'b1;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      rdv_cnt++;
      rdv_data = bus.rd_data;
      if (!(prev_ss === 1'b0 && SS_n === 1'b1)) rdv_misplaced++;
    end
    prev_ss = SS_n;
  end

  // ---------------- host helpers ----------------------------------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] d);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_data  = d;
    wait_ready("ready_seen");
    check("idle_at_accept", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = ~t;
    bus.cmd_data  = ~d;
  endtask

  task automatic wait_frames(input int start, input int n);
    int k = 0;
    while (frame_done < start + n && k < 600) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    check("frames_done", frame_done - start, n);
  endtask

  // ---------------- watchdog --------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence -----------------------------------
  logic [1:0] q_type [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [7:0] q_data [4] = '{8'hE7, 8'hAA, 8'hE7, 8'h00};

  initial begin
    int s, r0, a0, g0, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'b00;
    bus.cmd_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ss_n",      {31'd0, SS_n},          32'd1);
    check("rst_mosi",      {31'd0, MOSI},          32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_rd_valid",  {31'd0, bus.rd_valid},  32'd0);
    check("rst_rd_data",   {24'd0, bus.rd_data},   32'h00);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_low_before_edge", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", {31'd0, bus.cmd_ready}, 32'd1);

    // 1: write address 0xE7
    s = frame_done; r0 = rdv_cnt;
    send_cmd(2'b00, 8'hE7);
    wait_frames(s, 1);
    check("t1_len",    last_len,          12);
    check("t1_setup",  {31'd0, last_bits[11]}, 32'd0);
    check("t1_mosi",   {21'd0, last_bits[10:0]}, 32'h0E7);
    check("t1_rx",     {22'd0, last_w},   32'h0E7);
    check("t1_no_rdv", rdv_cnt,           r0);

    // 2: write data 0x55 into RAM[0xE7]
    s = frame_done;
    send_cmd(2'b01, 8'h55);
    wait_frames(s, 1);
    check("t2_len",  last_len, 12);
    check("t2_mosi", {21'd0, last_bits[10:0]}, 32'h155);
    check("t2_ram",  {24'd0, ram[8'hE7]}, 32'h55);

    // 3: read address 0x03
    s = frame_done;
    send_cmd(2'b10, 8'h03);
    wait_frames(s, 1);
    check("t3_len",    last_len, 12);
    check("t3_mosi",   {21'd0, last_bits[10:0]}, 32'h603);
    check("t3_rx",     {22'd0, last_w}, 32'h203);
    check("t3_no_rdv", rdv_cnt, r0);

    // 4: read data, RAM[0x03] = 0xFE
    s = frame_done;
    send_cmd(2'b11, 8'h00);
    wait_frames(s, 1);
    check("t4_len",      last_len, RD_FRAME_LEN);
    check("t4_mosi",     {11'd0, last_bits[20:0]}, 32'h0E0000);
    check("t4_rdv_once", rdv_cnt, r0 + 1);
    check("t4_rdv_data", {24'd0, rdv_data}, 32'hFE);
    repeat (20) @(negedge clk);
    check("t4_rd_hold",  {24'd0, bus.rd_data}, 32'hFE);
    check("t4_rdv_low",  {31'd0, bus.rd_valid}, 32'd0);

    // 5: four commands with cmd_valid held high throughout
    s = frame_done; r0 = rdv_cnt; g0 = start_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_type = q_type[i];
      bus.cmd_data = q_data[i];
      wait_ready("t5_ready");
      check("t5_idle_at_accept", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    wait_frames(s, 4);
    for (int i = 1; i < 4; i++)
      check("t5_gap", gap_log[(g0 + i) % 64], GAP_CYC + 1);
    check("t5_ram",      {24'd0, ram[8'hE7]}, 32'hAA);
    check("t5_rdv_once", rdv_cnt, r0 + 1);
    check("t5_rdv_data", {24'd0, rdv_data}, 32'hAA);
    check("t5_rd_data",  {24'd0, bus.rd_data}, 32'hAA);

    // 6: reset during SHIFT bit W[5] of a write, then a clean write
    s = frame_done; r0 = rdv_cnt; a0 = abort_cnt;
    send_cmd(2'b01, 8'hA5);
    k = 0;
    while (flen < 7 && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("t6_at_bit5",   flen, 7);
    check("t6_mosi_pre",  {31'd0, MOSI}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_ss_n_abort", {31'd0, SS_n}, 32'd1);
    check("t6_mosi_abort", {31'd0, MOSI}, 32'd0);
    check("t6_busy_abort", {31'd0, bus.busy}, 32'd0);
    check("t6_rd_data_rst", {24'd0, bus.rd_data}, 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_release", {31'd0, bus.cmd_ready}, 32'd1);
    check("t6_aborted",       abort_cnt, a0 + 1);
    send_cmd(2'b00, 8'h3C);
    wait_frames(s, 1);
    check("t6_len",    last_len, 12);
    check("t6_mosi",   {21'd0, last_bits[10:0]}, 32'h03C);
    check("t6_rx",     {22'd0, last_w}, 32'h03C);
    check("t6_no_rdv", rdv_cnt, r0);

    check("rdv_misplaced", rdv_misplaced, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
